// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_seq
//  Description : Registered, parametrised two-level address decoder with a
//                valid/ready input handshake and a sweep mode that walks the
//                one-hot output from a start index up to the top index.
//                Optional macro DECODER_SEQ_ACTIVE_LOW_EN makes Y active-low
//                (selected bit 0, all others 1; idle/reset value all ones).
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_seq #(
    parameter  int ADDR_W     = 6,
    parameter  int HI_W       = 3,
    parameter  int SWEEP_HOLD = 1,
    localparam int OUT_W      = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] A,
    output logic [OUT_W-1:0]  Y,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int LO_W  = ADDR_W - HI_W;
    localparam int GRP_N = 2**HI_W;
    localparam int LO_N  = 2**LO_W;

    localparam logic [GRP_N-1:0]  c_GRP_ONE     = {{(GRP_N-1){1'b0}}, 1'b1};
    localparam logic [LO_N-1:0]   c_LO_ONE      = {{(LO_N-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_IDX_TOP     = {ADDR_W{1'b1}};
    localparam logic [7:0]        c_HOLD_RELOAD = 8'(SWEEP_HOLD - 1);

    // Idle value of Y doubles as the XOR mask that applies output polarity.
`ifdef DECODER_SEQ_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0]  c_Y_IDLE      = {OUT_W{1'b1}};
`else
    localparam logic [OUT_W-1:0]  c_Y_IDLE      = {OUT_W{1'b0}};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_idx, w_idx_nx;
    logic [7:0]        r_hold, w_hold_nx;
    logic              r_drain, w_drain_nx;

    logic              w_accept;
    logic              w_inj_valid;
    logic [ADDR_W-1:0] w_inj_addr;
    logic              w_inj_last;

    logic              r_s1_valid;
    logic [GRP_N-1:0]  r_s1_grp;
    logic [LO_W-1:0]   r_s1_lo;
    logic              r_s1_last;

    logic [LO_N-1:0]   w_lo_hot;
    logic [OUT_W-1:0]  w_y_dec;

    // Gated by rst_n so the handshake is closed while reset is held.
    assign in_ready = rst_n && en && (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state != S_IDLE);

    // Next-state logic and stage-1 injection select (direct request or sweep index).
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_hold_nx   = r_hold;
        w_drain_nx  = r_drain;
        w_inj_valid = 1'b0;
        w_inj_addr  = A;
        w_inj_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (mode) begin
                        w_state_nx = S_SWEEP;
                        w_idx_nx   = A;
                        w_hold_nx  = c_HOLD_RELOAD;
                    end else begin
                        w_inj_valid = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                w_inj_valid = 1'b1;
                w_inj_addr  = r_idx;
                if (r_hold == 8'd0) begin
                    if (r_idx == c_IDX_TOP) begin
                        w_inj_last = 1'b1;
                        w_state_nx = S_DRAIN;
                        w_drain_nx = 1'b0;
                    end else begin
                        w_idx_nx  = r_idx + 1'b1;
                        w_hold_nx = c_HOLD_RELOAD;
                    end
                end else begin
                    w_hold_nx = r_hold - 8'd1;
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_state_nx = S_IDLE;
                    w_drain_nx = 1'b0;
                end else begin
                    w_drain_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        // Dropping en aborts everything: no injection, no done, back to IDLE.
        if (!en) begin
            w_state_nx  = S_IDLE;
            w_drain_nx  = 1'b0;
            w_inj_valid = 1'b0;
            w_inj_last  = 1'b0;
        end
    end

    // FSM and sweep bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_hold  <= w_hold_nx;
            r_drain <= w_drain_nx;
        end
    end

    // Stage 1: group one-hot from the upper bits, low bits carried forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_grp   <= '0;
            r_s1_lo    <= '0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_inj_valid;
            r_s1_grp   <= c_GRP_ONE << w_inj_addr[ADDR_W-1:LO_W];
            r_s1_lo    <= w_inj_addr[LO_W-1:0];
            r_s1_last  <= w_inj_last;
        end
    end

    assign w_lo_hot = c_LO_ONE << r_s1_lo;

    generate
        for (genvar g = 0; g < GRP_N; g++) begin : g_group
            assign w_y_dec[g*LO_N +: LO_N] = r_s1_grp[g] ? w_lo_hot : {LO_N{1'b0}};
        end
    endgenerate

    // Stage 2: registered output with polarity applied; idle value when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y         <= c_Y_IDLE;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (en && r_s1_valid) begin
            Y         <= w_y_dec ^ c_Y_IDLE;
            out_valid <= 1'b1;
            done      <= r_s1_last;
        end else begin
            Y         <= c_Y_IDLE;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_seq
//  Description : Scoreboard bench for decoder_seq. Three instances: default
//                geometry with SWEEP_HOLD=2, default geometry with
//                SWEEP_HOLD=1, and ADDR_W=4/HI_W=1. Expected values honour
//                DECODER_SEQ_ACTIVE_LOW_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_seq;

`ifdef DECODER_SEQ_ACTIVE_LOW_EN
    localparam logic c_POL = 1'b1;
`else
    localparam logic c_POL = 1'b0;
`endif

    typedef struct {
        logic [63:0] y;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, en, mode;
    logic        in_valid_a, in_valid_b, in_valid_c;
    logic [5:0]  a_a, a_b;
    logic [3:0]  a_c;
    logic        in_ready_a, in_ready_b, in_ready_c;
    logic [63:0] y_a, y_b;
    logic [15:0] y_c;
    logic        ov_a, ov_b, ov_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] q_c[$];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    decoder_seq #(.ADDR_W(6), .HI_W(3), .SWEEP_HOLD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .A(a_a), .Y(y_a),
        .out_valid(ov_a), .busy(busy_a), .done(done_a)
    );

    decoder_seq #(.ADDR_W(6), .HI_W(3), .SWEEP_HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .A(a_b), .Y(y_b),
        .out_valid(ov_b), .busy(busy_b), .done(done_b)
    );

    decoder_seq #(.ADDR_W(4), .HI_W(1), .SWEEP_HOLD(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .A(a_c), .Y(y_c),
        .out_valid(ov_c), .busy(busy_c), .done(done_c)
    );

    function automatic logic [63:0] exp64(input int idx);
        logic [63:0] one;
        one = 64'd1;
        return c_POL ? ~(one << idx) : (one << idx);
    endfunction

    function automatic logic [15:0] exp16(input int idx);
        logic [15:0] one;
        one = 16'd1;
        return c_POL ? ~(one << idx) : (one << idx);
    endfunction

    function automatic logic [63:0] idle64();
        return c_POL ? {64{1'b1}} : 64'd0;
    endfunction

    function automatic logic [15:0] idle16();
        return c_POL ? {16{1'b1}} : 16'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push_a(input int idx, input logic d);
        exp_t e;
        e.y = exp64(idx);
        e.done = d;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int idx, input logic d);
        exp_t e;
        e.y = exp64(idx);
        e.done = d;
        q_b.push_back(e);
    endtask

    task automatic wait_empty(input string name);
        int i;
        i = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && i < 60) begin
            @(negedge clk);
            #1;
            i++;
        end
        check(name, 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);
    endtask

    // Monitor for instance A: pop on every presented output.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ov_a) begin
                if (q_a.size() == 0) check("a_unexpected_valid", 64'd1, 64'd0);
                else begin
                    e = q_a.pop_front();
                    check("a_Y", y_a, e.y);
                    check("a_done", 64'(done_a), 64'(e.done));
                end
            end else if (done_a) check("a_done_without_valid", 64'd1, 64'd0);
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ov_b) begin
                if (q_b.size() == 0) check("b_unexpected_valid", 64'd1, 64'd0);
                else begin
                    e = q_b.pop_front();
                    check("b_Y", y_b, e.y);
                    check("b_done", 64'(done_b), 64'(e.done));
                end
            end else if (done_b) check("b_done_without_valid", 64'd1, 64'd0);
        end
    end

    // Monitor for instance C.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && ov_c) begin
            if (q_c.size() == 0) check("c_unexpected_valid", 64'd1, 64'd0);
            else begin
                e = q_c.pop_front();
                check("c_Y", 64'(y_c), 64'(e));
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
        a_a = '0; a_b = '0; a_c = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_Y_a", y_a, idle64());
        check("rst_Y_c", 64'(y_c), 64'(idle16()));
        check("rst_out_valid", 64'(ov_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        en = 1'b1;
        #1;
        check("rst_in_ready_low", 64'(in_ready_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready_a), 64'd1);
        check("rel_Y", y_a, idle64());

        // Direct decode, back-to-back: 0, 37, 63.
        mode = 1'b0; in_valid_a = 1'b1; a_a = 6'd0; push_a(0, 1'b0);
        @(posedge clk); #1;
        a_a = 6'd37; push_a(37, 1'b0);
        @(posedge clk); #1;
        a_a = 6'd63; push_a(63, 1'b0);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("direct_after_Y", y_a, idle64());
        check("direct_after_valid", 64'(ov_a), 64'd0);
        wait_empty("direct_drained");

        // Sweep from 60 with hold 2.
        @(negedge clk);
        in_valid_a = 1'b1; mode = 1'b1; a_a = 6'd60;
        for (int i = 60; i <= 63; i++) begin
            push_a(i, 1'b0);
            push_a(i, i == 63);
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0; mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("sweep_in_ready_low", 64'(in_ready_a), 64'd0);
            check("sweep_busy", 64'(busy_a), 64'd1);
        end
        @(negedge clk);
        check("sweep_in_ready_back", 64'(in_ready_a), 64'd1);
        check("sweep_busy_clear", 64'(busy_a), 64'd0);
        wait_empty("sweep_drained");

        // Sweep starting at the top index with hold 1.
        @(negedge clk);
        in_valid_b = 1'b1; mode = 1'b1; a_b = 6'd63;
        push_b(63, 1'b1);
        @(posedge clk); #1;
        in_valid_b = 1'b0; mode = 1'b0;
        repeat (3) @(negedge clk);
        check("top_busy_drain", 64'(busy_b), 64'd1);
        @(negedge clk);
        check("top_in_ready_back", 64'(in_ready_b), 64'd1);
        check("top_busy_clear", 64'(busy_b), 64'd0);
        wait_empty("top_drained");

        // Abort: sweep from 0, drop en while bit5 is shown.
        @(negedge clk);
        in_valid_a = 1'b1; mode = 1'b1; a_a = 6'd0;
        for (int i = 0; i <= 5; i++) begin
            push_a(i, 1'b0);
            if (i < 5) push_a(i, 1'b0);
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0; mode = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_Y_bit5", y_a, exp64(5));
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_Y", y_a, idle64());
        check("abort_valid", 64'(ov_a), 64'd0);
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_in_ready_en_low", 64'(in_ready_a), 64'd0);
        en = 1'b1;
        #1;
        check("abort_in_ready_en_high", 64'(in_ready_a), 64'd1);
        wait_empty("abort_drained");
        repeat (3) @(negedge clk);
        check("abort_quiet", 64'(ov_a), 64'd0);

        // Narrow geometry: ADDR_W=4, HI_W=1, A=9.
        @(negedge clk);
        in_valid_c = 1'b1; mode = 1'b0; a_c = 4'd9;
        q_c.push_back(exp16(9));
        @(posedge clk); #1;
        in_valid_c = 1'b0;
        @(negedge clk);
        check("c_not_yet", 64'(y_c), 64'(idle16()));
        repeat (2) @(negedge clk);
        check("c_idle_after", 64'(y_c), 64'(idle16()));
        wait_empty("c_drained");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
